// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding the UART transmitter.
// Producers push up to one byte per clock. A four-state launcher pops one byte
// at a time into uart_tx through the start_tx / data_tx / idle_ready_tx handshake.
// Optional build macro UART_TXQ_OVERFLOW_EN adds a sticky overflow flag
// (output overflow) and its clear input (input ovf_clr).
module uart_tx_queue #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  flush,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    input  logic                  idle_ready_tx,
    output logic                  start_tx,
    output logic [DATA_WIDTH-1:0] data_tx
`ifdef UART_TXQ_OVERFLOW_EN
    ,
    output logic                  overflow,
    input  logic                  ovf_clr
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO = (DEPTH_LOG2+1)'(1'b0);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1'b1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(1'b0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1'b1);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = DATA_WIDTH'(1'b0);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    state_t                state_r;
    logic                  push_s;
    logic                  launch_s;
`ifdef UART_TXQ_OVERFLOW_EN
    logic                  drop_s;
`endif

    assign full  = (count == CNT_FULL);
    assign empty = (count == CNT_ZERO);

    // Decide push, launch (pop) and drop for this cycle; flush suppresses all of them.
    always_comb begin
        push_s   = 1'b0;
        launch_s = 1'b0;
`ifdef UART_TXQ_OVERFLOW_EN
        drop_s   = 1'b0;
`endif
        if (flush) begin
            push_s   = 1'b0;
            launch_s = 1'b0;
        end else begin
            push_s   = wr_en & ~full;
            launch_s = (state_r == ST_IDLE) & ~empty & idle_ready_tx;
`ifdef UART_TXQ_OVERFLOW_EN
            drop_s   = wr_en & full;
`endif
        end
    end

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; a flush drops everything not yet launched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count    <= CNT_ZERO;
        end else if (flush) begin
            rd_ptr_r <= wr_ptr_r;
            count    <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (launch_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, launch_s})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Launcher: one-cycle start pulse, then wait for the transmitter to go busy and idle again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            start_tx <= 1'b0;
            data_tx  <= DATA_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (launch_s) begin
                        start_tx <= 1'b1;
                        data_tx  <= mem_r[rd_ptr_r];
                        state_r  <= ST_LAUNCH;
                    end else begin
                        start_tx <= 1'b0;
                    end
                end
                ST_LAUNCH: begin
                    start_tx <= 1'b0;
                    state_r  <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    // Do not trust idle_ready_tx until the transmitter has dropped it once.
                    start_tx <= 1'b0;
                    if (!idle_ready_tx) begin
                        state_r <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    start_tx <= 1'b0;
                    if (idle_ready_tx) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    start_tx <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef UART_TXQ_OVERFLOW_EN
    // Sticky overflow flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop_s) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue with a simple transmitter model and a
// byte scoreboard. Overflow checks are built when UART_TXQ_OVERFLOW_EN is defined.
module tb_uart_tx_queue;

    localparam int LAG  = 3;
    localparam int BUSY = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       flush = 1'b0;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       idle_ready_tx;
    logic       start_tx;
    logic [7:0] data_tx;
`ifdef UART_TXQ_OVERFLOW_EN
    logic       overflow;
    logic       ovf_clr = 1'b0;
`endif

    logic       tx_auto = 1'b1;
    logic       man_ready = 1'b1;
    int         tx_cnt = 0;
    logic       model_ready;

    int         n_checks = 0;
    int         n_fail = 0;
    int         n_start = 0;
    int         n_exp_start = 0;
    int         snap;
    logic [7:0] exp_q[$];
    logic       prev_start = 1'b0;
    logic [7:0] prev_data = 8'h00;

    uart_tx_queue #(.DEPTH_LOG2(4), .DATA_WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .flush(flush),
        .full(full),
        .empty(empty),
        .count(count),
        .idle_ready_tx(idle_ready_tx),
        .start_tx(start_tx),
        .data_tx(data_tx)
`ifdef UART_TXQ_OVERFLOW_EN
        ,
        .overflow(overflow),
        .ovf_clr(ovf_clr)
`endif
    );

    always #5 clk = ~clk;

    // Transmitter model: ready stays high LAG cycles after a launch, then low BUSY cycles.
    assign model_ready   = !(tx_cnt > 0 && tx_cnt <= BUSY);
    assign idle_ready_tx = tx_auto ? model_ready : man_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_push(input logic [7:0] b, input bit accept);
        wr_en   = 1'b1;
        wr_data = b;
        if (accept) begin
            exp_q.push_back(b);
            n_exp_start++;
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int k = 0;
        while (exp_q.size() != 0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk("drain_done", 32'(exp_q.size()), 32'd0);
        repeat (20) @(negedge clk);
    endtask

    // Transmitter model state.
    always @(negedge clk) begin
        if (rst) tx_cnt <= 0;
        else if (start_tx) tx_cnt <= LAG + BUSY;
        else if (tx_cnt > 0) tx_cnt <= tx_cnt - 1;
    end

    // Output monitor: pops the scoreboard on each launch and watches pulse width, data hold and occupancy.
    always @(negedge clk) begin
        if (rst) begin
            prev_start = 1'b0;
            prev_data  = 8'h00;
        end else begin
            chk("count_le_16", 32'(count <= 5'd16), 32'd1);
            if (start_tx) begin
                n_start++;
                chk("single_cycle_pulse", 32'(prev_start), 32'd0);
                chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("data_tx_order", 32'(data_tx), 32'(exp_q.pop_front()));
            end else begin
                chk("data_tx_hold", 32'(data_tx), 32'(prev_data));
            end
            prev_start = start_tx;
            prev_data  = data_tx;
        end
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_start_tx", 32'(start_tx), 32'd0);
        chk("rst_data_tx", 32'(data_tx), 32'd0);
`ifdef UART_TXQ_OVERFLOW_EN
        chk("rst_overflow", 32'(overflow), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Single push: count=1 after edge N, launch at edge N+1, one-cycle pulse
        drive_push(8'hA5, 1'b1);
        chk("t1_count_after_push", 32'(count), 32'd1);
        chk("t1_no_bypass", 32'(start_tx), 32'd0);
        @(negedge clk);
        chk("t1_start_tx", 32'(start_tx), 32'd1);
        chk("t1_data_tx", 32'(data_tx), 32'hA5);
        chk("t1_empty", 32'(empty), 32'd1);
        @(negedge clk);
        chk("t1_pulse_end", 32'(start_tx), 32'd0);
        repeat (20) @(negedge clk);
        chk("t1_one_launch", 32'(n_start), 32'd1);

        // Fill to 16 with the transmitter held busy, then drop a 17th byte
        tx_auto   = 1'b0;
        man_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) drive_push(8'(i), 1'b1);
        chk("t2_count_full", 32'(count), 32'd16);
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_not_empty", 32'(empty), 32'd0);
        drive_push(8'hFF, 1'b0);
        chk("t2_count_after_drop", 32'(count), 32'd16);
        chk("t2_no_launch_busy", 32'(n_start), 32'd1);

        // Release the transmitter; a push in the launch cycle at count=16 is still dropped
        tx_auto = 1'b1;
        drive_push(8'hEE, 1'b0);
        chk("t4_count_after_pop", 32'(count), 32'd15);
        drive_push(8'h10, 1'b1);
        chk("t4_refill_16", 32'(count), 32'd16);
        for (int k = 0; k < 4; k++) begin
            repeat (19) @(negedge clk);
            drive_push(8'h11 + 8'(k), 1'b1);
        end
        wait_drain(500);
        chk("t4_launch_total", 32'(n_start), 32'(n_exp_start));

        // Flush with 5 queued and one frame in flight; simultaneous push is ignored
        for (int i = 0; i < 6; i++) drive_push(8'h50 + 8'(i), 1'b1);
        chk("t5_count_before_flush", 32'(count), 32'd5);
        repeat (3) @(negedge clk);
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h77;
        @(negedge clk);
        flush = 1'b0;
        wr_en = 1'b0;
        exp_q.delete();
        n_exp_start -= 5;
        chk("t5_count_flushed", 32'(count), 32'd0);
        chk("t5_empty_flushed", 32'(empty), 32'd1);
        chk("t5_data_in_flight", 32'(data_tx), 32'h50);
        snap = n_start;
        repeat (40) @(negedge clk);
        chk("t5_no_launch_after_flush", 32'(n_start), 32'(snap));
        chk("t5_data_kept", 32'(data_tx), 32'h50);
        drive_push(8'h3C, 1'b1);
        wait_drain(100);

`ifdef UART_TXQ_OVERFLOW_EN
        // Sticky overflow: set on drop, set beats clear, clear alone works, flush drop ignored
        tx_auto   = 1'b0;
        man_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) drive_push(8'hC0 + 8'(i), 1'b0);
        chk("t6_ovf_clear_when_full", 32'(overflow), 32'd0);
        drive_push(8'hFF, 1'b0);
        chk("t6_ovf_set", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        drive_push(8'hFE, 1'b0);
        ovf_clr = 1'b0;
        chk("t6_ovf_set_wins", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("t6_ovf_cleared", 32'(overflow), 32'd0);
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hFD;
        @(negedge clk);
        flush = 1'b0;
        wr_en = 1'b0;
        chk("t6_no_ovf_on_flush", 32'(overflow), 32'd0);
        chk("t6_count_flushed", 32'(count), 32'd0);
        tx_auto = 1'b1;
        repeat (5) @(negedge clk);
`endif

        // Reset mid-frame clears queue and launcher at once
        drive_push(8'h61, 1'b1);
        drive_push(8'h62, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t7_rst_count", 32'(count), 32'd0);
        chk("t7_rst_empty", 32'(empty), 32'd1);
        chk("t7_rst_start", 32'(start_tx), 32'd0);
        chk("t7_rst_data", 32'(data_tx), 32'd0);
        exp_q.delete();
        n_exp_start -= 1;
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("final_launch_total", 32'(n_start), 32'(n_exp_start));
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
Byte FIFO placed directly upstream of the UART transmitter inside the uart wrapper. Producers push bytes at up to one per clock. The queue drains them one at a time into the transmitter through its start_tx / data_tx / idle_ready_tx handshake, so software or parsers never poll transmitter readiness per byte.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (16 entries); legal range 1..8
DATA_WIDTH, 8, byte width; must match the transmitter data width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
wr_en  input  1  push request, sampled on rising clk
wr_data  input  DATA_WIDTH  byte to push
flush  input  1  synchronous discard of all queued bytes
full  output  1  FIFO holds 2^DEPTH_LOG2 entries
empty  output  1  FIFO holds 0 entries
count  output  DEPTH_LOG2+1  current occupancy
idle_ready_tx  input  1  transmitter idle/ready, from uart_tx
start_tx  output  1  one-cycle launch pulse to uart_tx
data_tx  output  DATA_WIDTH  byte presented to uart_tx

Behaviour:
- Reset (async, rst=1): start_tx=0, data_tx=0, count=0, empty=1, full=0, pointers=0, FSM=IDLE. Memory contents are don't-care.
- Storage:
  - Circular buffer with DEPTH_LOG2-bit read/write pointers; wrap modulo depth.
  - count is a separate register.
  - full = (count == 2^DEPTH_LOG2); empty = (count == 0). Both are derived combinationally from the registered count.
- Push:
  - wr_en=1 and full=0: write mem[wr_ptr], wr_ptr+1, count+1 at the edge.
  - wr_en=1 and full=1: byte dropped. No state change, even if a pop occurs the same cycle.
- Pop happens only on launch (see FSM). Push and pop in the same cycle: count unchanged, both pointers advance.
- No bypass: a byte written at edge N is launchable no earlier than edge N+1, so start_tx is high during cycle N+1..N+2.
- FSM (registered), four states:
  - IDLE: if count!=0 and idle_ready_tx=1 and flush=0, then at the edge: start_tx<=1, data_tx<=mem[rd_ptr], rd_ptr+1, count-1, go to LAUNCH. Otherwise stay.
  - LAUNCH: start_tx<=0 (pulse is exactly one cycle), go to WAIT_BUSY.
  - WAIT_BUSY: stay while idle_ready_tx=1; on idle_ready_tx=0 go to WAIT_DONE. This guards against re-launch before the transmitter acknowledges.
  - WAIT_DONE: stay while idle_ready_tx=0; on idle_ready_tx=1 go to IDLE.
- data_tx holds its value from launch until the next launch; it is never changed mid-frame.
- Throughput: after idle_ready_tx rises in WAIT_DONE, the next start_tx asserts 2 edges later (WAIT_DONE->IDLE, IDLE->launch).
- flush=1:
  - rd_ptr<=wr_ptr, count<=0 at the edge.
  - A simultaneous wr_en is ignored.
  - Blocks a launch that cycle.
  - An in-flight frame (LAUNCH/WAIT_*) completes normally; data_tx is not altered.
- Reset mid-frame: queue and FSM clear immediately. The transmitter is reset by the same rst.

Optional Feature:
UART_TXQ_OVERFLOW_EN
- Defined: adds output port overflow (1 bit) and input port ovf_clr (1 bit).
  - overflow sets on any dropped push (wr_en=1 and full=1, not during flush) and stays sticky.
  - ovf_clr=1 clears it at the edge.
  - Set wins over a simultaneous clear.
  - Reset value 0.
- Undefined: neither port exists; dropped pushes are silent.

Test Plan:
- Reset then single push 0xA5 at edge N with idle_ready_tx=1 -> count=1 after N; start_tx=1 for exactly one cycle after edge N+1; data_tx=0xA5; empty=1 after N+1.
- Push 16 bytes 0x00..0x0F back-to-back with idle_ready_tx=0 -> full=1, count=16; 17th push 0xFF dropped; raise idle_ready_tx and model the transmitter -> bytes emerge 0x00..0x0F in order, 0xFF never seen.
- Transmitter model holds idle_ready_tx high 3 cycles after start_tx, then low 10 cycles -> exactly one start_tx per frame; no second pulse during the 3-cycle lag.
- Push 20 bytes while draining, covering pointer wrap and simultaneous push/pop at count=16 -> output order is exact; count is never more than 16 and never negative.
- 5 bytes queued, one frame in flight, flush=1 together with wr_en=1 (0x77) -> count=0; in-flight data_tx unchanged; no further start_tx; 0x77 never sent.
- With UART_TXQ_OVERFLOW_EN: overfill by one -> overflow=1; ovf_clr together with another drop -> overflow stays 1; ovf_clr alone -> overflow=0.
